fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch buffer that sits directly downstream of the pc stage and instruction memory, and upstream of decode.
- Captures {pc, instruction} pairs produced each cycle by the fetch path.
- Buffers them in a small FIFO and presents them to decode over a valid/ready handshake.
- Decouples pc advance from decode stalls and discards wrong-path instructions on a branch flush.

Parameters:
ADDR_W, 32, width of pc / instruction address
INSTR_W, 32, width of instruction word
DEPTH, 4, number of queue entries; power of two, >= 2
CNT_W, 3, width of occupancy count; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  fetch path presents a valid pc/instr pair
in_ready  output  1  queue can accept this cycle
in_pc  input  ADDR_W  address of fetched instruction
in_instr  input  INSTR_W  fetched instruction word
flush  input  1  branch/jump taken: discard all buffered entries
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_pc  output  ADDR_W  pc of head entry
out_pc_plus1  output  ADDR_W  out_pc + 1, modulo 2^ADDR_W (word-addressed)
out_instr  output  INSTR_W  head instruction word
count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr, rd_ptr, count = 0; out_valid = 0.
  - out_pc, out_instr, out_pc_plus1 = 0; storage contents don't-care.
- Write and read:
  - Write occurs when in_valid && in_ready. Read occurs when out_valid && out_ready.
  - in_ready = (count != DEPTH) && !flush. Purely combinational from registered count, plus flush.
  - out_valid = (count != 0). out_pc/out_instr show the head entry combinationally (first-word fall-through).
  - Latency: a pair written at edge N is visible on out_* after edge N, i.e. in cycle N+1. No same-cycle bypass.
- Simultaneous read and write:
  - Both happen; count unchanged.
  - Legal when full: in_ready stays 0 when full, so no write occurs.
  - Legal when empty: out_valid is 0, so no read occurs.
- Pointers:
  - log2(DEPTH) bits, wrap naturally modulo DEPTH.
  - count updates +1 on write only, -1 on read only.
- Flush:
  - At the posedge where flush=1: wr_ptr=rd_ptr=0, count=0. Any concurrent write and read are discarded; in_ready is already forced 0.
  - Cycle after flush: out_valid=0, in_ready=1.
- Reset mid-operation: identical to flush plus output data clear. rst has priority over flush.
- out_pc_plus1: arithmetic is ADDR_W bits, carry dropped (0xFFFFFFFF+1 = 0).
- Handshake rules:
  - Upstream must hold in_pc/in_instr stable while in_valid && !in_ready.
  - Queue holds out_* stable while out_valid && !out_ready.
- Illegal states: count never exceeds DEPTH. Assertion in bench: write never occurs when count==DEPTH.

Optional Feature:
FETCHQ_STATS_EN
- Defined: adds output ports stall_cycles[15:0] and flush_count[15:0]. Both reset to 0 and saturate at 0xFFFF.
  - stall_cycles increments each cycle in_valid && !in_ready.
  - flush_count increments on each flush=1 cycle.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg: ADDR_W, INSTR_W constants; typedef fetch_entry_t {pc, instr}.
- One sub-module fetchq_mem: DEPTH x (ADDR_W+INSTR_W) register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). No reset on the array.
- Pointer/count/flush control stays in fetch_queue.

Test Plan:
- Reset then idle: rst=1 two cycles -> out_valid=0, count=0, in_ready=1, out_pc=0.
- Fill: in_valid=1, out_ready=0, in_pc=0..4, instr=0xA0..0xA4 -> first 4 accepted, count=4, in_ready=0 on 5th. Head out_pc=0, out_instr=0xA0, out_pc_plus1=1.
- Drain in order: then out_ready=1, in_valid=0 -> out_pc 0,1,2,3 on consecutive cycles; out_valid=0 after 4th; count=0.
- Concurrent read/write at steady state: count=2, in_valid=1, out_ready=1 for 10 cycles -> count stays 2, pointers wrap, output order matches input order exactly.
- Flush with concurrent write: count=3, flush=1, in_valid=1 (pc=0x40) -> next cycle count=0, out_valid=0. pc 0x40 never appears on out_pc.
- Wrap arithmetic and rst priority: in_pc=0xFFFFFFFF -> out_pc_plus1=0. Assert rst and flush together with count=2 -> count=0, out_instr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and the {pc, instr} entry type.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetchq_mem.sv
// Fetch queue storage: register array, one write port, asynchronous read port.
// Contents are not reset; validity is tracked by the owning queue.
module fetchq_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer between pc/imem and decode, with branch flush.
// Optional stall/flush statistics counters when FETCHQ_STATS_EN is defined.
module fetch_queue #(
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus1,
    output logic [INSTR_W-1:0] out_instr,
`ifdef FETCHQ_STATS_EN
    output logic [15:0]        stall_cycles,
    output logic [15:0]        flush_count,
`endif
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               wr_en;
    logic               rd_en;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;

    assign in_ready  = (cnt != CNT_W'(DEPTH)) && !flush;
    assign out_valid = (cnt != '0);
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;
    assign count     = cnt;

    fetchq_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign head_pc    = head[ENTRY_W-1:INSTR_W];
    assign head_instr = head[INSTR_W-1:0];

    // Storage is never reset, so an empty queue drives zeros rather than stale data.
    always_comb begin
        out_pc       = '0;
        out_pc_plus1 = '0;
        out_instr    = '0;
        if (out_valid) begin
            out_pc       = head_pc;
            out_pc_plus1 = head_pc + ADDR_W'(1);
            out_instr    = head_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !rd_en) begin
                cnt <= cnt + CNT_W'(1);
            end else if (rd_en && !wr_en) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (in_valid && !in_ready && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (flush && flush_q != 16'hFFFF) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus1;
    logic [31:0] out_instr;
    logic [2:0]  count;
`ifdef FETCHQ_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus1 (out_pc_plus1),
        .out_instr    (out_instr),
`ifdef FETCHQ_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .count        (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A write must never be accepted while the queue is full.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready && count == 3'd4) begin
            errors++;
            $display("FAIL write_when_full: got in_ready=1, expected 0 (t=%0t)", $time);
        end
    end

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic [2:0]  e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_pc;
        logic [31:0] e_p1;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] pc, logic [31:0] ins,
                                logic ordy, logic [2:0] c, logic ov, logic ir,
                                logic [31:0] epc, logic [31:0] ep1, logic [31:0] eins);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.instr = ins; v.ordy = ordy;
        v.e_cnt = c; v.e_ov = ov; v.e_ir = ir; v.e_pc = epc; v.e_p1 = ep1; v.e_instr = eins;
        return v;
    endfunction

    task automatic idle();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
    endtask

    // Reference model state
    fetch_entry_t mq[$];

    task automatic model_check(input string tag);
        logic [31:0] epc, ep1, eins;
        logic        ov;
        ov   = (mq.size() != 0);
        epc  = ov ? mq[0].pc : 32'h0;
        ep1  = ov ? mq[0].pc + 32'd1 : 32'h0;
        eins = ov ? mq[0].instr : 32'h0;
        chk({tag, "_count"}, 32'(count), 32'(mq.size()));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'((mq.size() != 4) && !flush));
        chk({tag, "_out_pc"}, out_pc, epc);
        chk({tag, "_out_pc_plus1"}, out_pc_plus1, ep1);
        chk({tag, "_out_instr"}, out_instr, eins);
    endtask

    task automatic model_step();
        bit wr, rd;
        fetch_entry_t e;
        wr = in_valid && (mq.size() != 4) && !flush;
        rd = (mq.size() != 0) && out_ready;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (rd) void'(mq.pop_front());
            if (wr) begin
                e.pc = in_pc; e.instr = in_instr;
                mq.push_back(e);
            end
        end
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(1,0,0,32'h0,32'h0,0,         0,0,1,32'h0,32'h0,32'h0);
        vecs[1]  = mk(1,0,0,32'h0,32'h0,0,         0,0,1,32'h0,32'h0,32'h0);
        vecs[2]  = mk(0,0,1,32'h0,32'hA0,0,        1,1,1,32'h0,32'h1,32'hA0);
        vecs[3]  = mk(0,0,1,32'h1,32'hA1,0,        2,1,1,32'h0,32'h1,32'hA0);
        vecs[4]  = mk(0,0,1,32'h2,32'hA2,0,        3,1,1,32'h0,32'h1,32'hA0);
        vecs[5]  = mk(0,0,1,32'h3,32'hA3,0,        4,1,0,32'h0,32'h1,32'hA0);
        vecs[6]  = mk(0,0,1,32'h4,32'hA4,0,        4,1,0,32'h0,32'h1,32'hA0);
        vecs[7]  = mk(0,0,0,32'h0,32'h0,1,         3,1,1,32'h1,32'h2,32'hA1);
        vecs[8]  = mk(0,0,0,32'h0,32'h0,1,         2,1,1,32'h2,32'h3,32'hA2);
        vecs[9]  = mk(0,0,0,32'h0,32'h0,1,         1,1,1,32'h3,32'h4,32'hA3);
        vecs[10] = mk(0,0,0,32'h0,32'h0,1,         0,0,1,32'h0,32'h0,32'h0);
        vecs[11] = mk(0,0,1,32'h10,32'hB0,0,       1,1,1,32'h10,32'h11,32'hB0);
        vecs[12] = mk(0,0,1,32'h11,32'hB1,0,       2,1,1,32'h10,32'h11,32'hB0);
        vecs[13] = mk(0,0,1,32'h12,32'hB2,0,       3,1,1,32'h10,32'h11,32'hB0);
        vecs[14] = mk(0,1,1,32'h40,32'hC0,1,       0,0,1,32'h0,32'h0,32'h0);
        vecs[15] = mk(0,0,0,32'h0,32'h0,0,         0,0,1,32'h0,32'h0,32'h0);
        vecs[16] = mk(0,0,1,32'hFFFFFFFF,32'hD0,0, 1,1,1,32'hFFFFFFFF,32'h0,32'hD0);
        vecs[17] = mk(0,0,1,32'h5,32'hD1,0,        2,1,1,32'hFFFFFFFF,32'h0,32'hD0);
        vecs[18] = mk(1,1,0,32'h0,32'h0,0,         0,0,1,32'h0,32'h0,32'h0);

        idle();
        @(negedge clk);

        // Directed table: apply inputs for one edge, then observe with inputs idle.
        for (int i = 0; i < 19; i++) begin
            rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
            in_pc = vecs[i].pc; in_instr = vecs[i].instr; out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            idle();
            #1;
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_out_pc_plus1", i), out_pc_plus1, vecs[i].e_p1);
            chk($sformatf("v%0d_out_instr", i), out_instr, vecs[i].e_instr);
        end

        // Steady-state concurrent read/write at occupancy 2; pointers wrap.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_pc = 32'h100 + 32'(i); in_instr = 32'hE00 + 32'(i);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_pc = 32'h102 + 32'(i); in_instr = 32'hE02 + 32'(i);
            #1;
            chk($sformatf("rw%0d_count", i), 32'(count), 32'd2);
            chk($sformatf("rw%0d_out_pc", i), out_pc, 32'h100 + 32'(i));
            chk($sformatf("rw%0d_out_instr", i), out_instr, 32'hE00 + 32'(i));
            @(posedge clk);
            #1;
        end
        idle();
        #1;
        chk("rw_end_count", 32'(count), 32'd2);
        chk("rw_end_out_pc", out_pc, 32'h10A);

        // Randomized traffic against the model, starting from reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        idle();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit hold;
            hold = in_valid && !in_ready;
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : $urandom;
                in_instr = $urandom;
            end
            #1;
            model_check("rnd");
            model_step();
            @(posedge clk);
            #1;
        end
        idle();
        #1;
        model_check("rnd_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
